// File: rtl/stopwatch_pkg.sv
// Shared state encoding, BCD digit limits and the per-digit increment helper
// used by the stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } sw_state_e;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_PAUSED = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] SEC_TENS_MAX = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX = 4'd5;
    localparam logic [3:0] UNITS_MAX    = 4'd9;

    // Returns {carry_out, next_digit}. Out-of-range digits fold back to 0.
    function automatic logic [4:0] bcd_step(input logic [3:0] d,
                                            input logic [3:0] dmax,
                                            input logic       cin);
        if (!cin)
            return {1'b0, d};
        if (d >= dmax)
            return {1'b1, 4'd0};
        return {1'b0, d + 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_edge.sv
// Button conditioner: SYNC_STAGES-deep synchronizer followed by a rising-edge
// detector whose history flop starts high, so a button held through reset is ignored.
module btn_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic evt
);

    localparam int CW = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [CW-1:0]          flush_q;
    logic                   flushing;

    // The history flop is held high until the chain has refilled after reset,
    // otherwise the zeros left in the chain would look like a released button.
    assign flushing = (flush_q != CW'(SYNC_STAGES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b1;
            flush_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
            prev_q <= sync_q[SYNC_STAGES-1] | (prev_q & flushing);
            if (flushing)
                flush_q <= flush_q + CW'(1);
        end
    end

    assign evt = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear controller with an mm:ss BCD time base advanced by a 1 Hz tick.
// All outputs come straight from flops.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int WRAP        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clr,
    input  logic       tick,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       ovf
);

    logic [2:0] btn_raw;
    logic [2:0] btn_evt;
    logic       start_evt, pause_evt, clr_evt;

    assign btn_raw = {clr, pause, start};

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_btn
        btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
            .clk (clk),
            .rst (rst),
            .btn (btn_raw[gi]),
            .evt (btn_evt[gi])
        );
    end

    assign start_evt = btn_evt[0];
    assign pause_evt = btn_evt[1];
    assign clr_evt   = btn_evt[2];

    logic [1:0] state_q, state_d;
    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic [3:0] mt_d, mu_d, st_d, su_d;
    logic [3:0] mt_n, mu_n, st_n, su_n;
    logic       c0, c1, c2, roll;
    logic       ovf_q, ovf_d;
    logic       running_q, done_q;
    logic       count_en;
    logic       hit_end;

    assign count_en = (state_q == S_RUN) && tick && !clr_evt;

    always_comb begin
        {c0,   su_n} = bcd_step(su_q, UNITS_MAX,    1'b1);
        {c1,   st_n} = bcd_step(st_q, SEC_TENS_MAX, c0);
        {c2,   mu_n} = bcd_step(mu_q, UNITS_MAX,    c1);
        {roll, mt_n} = bcd_step(mt_q, MIN_TENS_MAX, c2);
    end

    assign hit_end = count_en && roll && (WRAP == 0);

    always_comb begin
        state_d = state_q;
        mt_d    = mt_q;
        mu_d    = mu_q;
        st_d    = st_q;
        su_d    = su_q;
        ovf_d   = 1'b0;
        if (clr_evt) begin
            state_d = S_IDLE;
            mt_d    = '0;
            mu_d    = '0;
            st_d    = '0;
            su_d    = '0;
        end else begin
            // Without wrap, an overflowing tick freezes the display at 59:59.
            if (count_en && !hit_end) begin
                mt_d  = mt_n;
                mu_d  = mu_n;
                st_d  = st_n;
                su_d  = su_n;
                ovf_d = roll;
            end
            case (state_q)
                S_IDLE:   if (start_evt) state_d = S_RUN;
                S_RUN: begin
                    if (pause_evt)    state_d = S_PAUSED;
                    else if (hit_end) state_d = S_DONE;
                end
                S_PAUSED: if (start_evt) state_d = S_RUN;
                S_DONE:   state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mt_q      <= '0;
            mu_q      <= '0;
            st_q      <= '0;
            su_q      <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mt_q      <= mt_d;
            mu_q      <= mu_d;
            st_q      <= st_d;
            su_q      <= su_d;
            ovf_q     <= ovf_d;
            running_q <= (state_d == S_RUN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign min_tens  = mt_q;
    assign min_units = mu_q;
    assign sec_tens  = st_q;
    assign sec_units = su_q;
    assign state     = state_q;
    assign running   = running_q;
    assign done      = done_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a stop-at-59:59 and a wrapping instance share stimulus and are
// compared every cycle against a model that keeps elapsed time as a plain seconds count.
module tb_stopwatch_ctrl;

    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0, pause = 1'b0, clr = 1'b0, tick = 1'b0;

    logic [3:0] mt [2];
    logic [3:0] mu [2];
    logic [3:0] st [2];
    logic [3:0] su [2];
    logic [1:0] stt [2];
    logic       run [2];
    logic       dn [2];
    logic       ov [2];

    always #5 clk = ~clk;

    stopwatch_ctrl #(.WRAP(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clr(clr), .tick(tick),
        .min_tens(mt[0]), .min_units(mu[0]), .sec_tens(st[0]), .sec_units(su[0]),
        .state(stt[0]), .running(run[0]), .done(dn[0]), .ovf(ov[0])
    );

    stopwatch_ctrl #(.WRAP(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .clr(clr), .tick(tick),
        .min_tens(mt[1]), .min_units(mu[1]), .sec_tens(st[1]), .sec_units(su[1]),
        .state(stt[1]), .running(run[1]), .done(dn[1]), .ovf(ov[1])
    );

    int compared   = 0;
    int mismatched = 0;
    int m_secs [2];
    int m_state [2];
    bit m_ovf [2];
    int s_cd = 0, p_cd = 0, c_cd = 0;
    bit hold_start = 1'b1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_secs[i]  = 0;
            m_state[i] = M_IDLE;
            m_ovf[i]   = 1'b0;
        end
        s_cd = 0; p_cd = 0; c_cd = 0;
    endtask

    task automatic model_edge(input bit se, input bit pe, input bit ce, input bit t);
        bit hit_end;
        for (int i = 0; i < 2; i++) begin
            hit_end  = 1'b0;
            m_ovf[i] = 1'b0;
            if (ce) begin
                m_state[i] = M_IDLE;
                m_secs[i]  = 0;
            end else begin
                if (m_state[i] == M_RUN && t) begin
                    if (m_secs[i] == 3599) begin
                        if (i == 1) begin
                            m_secs[i] = 0;
                            m_ovf[i]  = 1'b1;
                        end else begin
                            hit_end = 1'b1;
                        end
                    end else begin
                        m_secs[i] = m_secs[i] + 1;
                    end
                end
                case (m_state[i])
                    M_IDLE:   if (se) m_state[i] = M_RUN;
                    M_RUN:    if (pe) m_state[i] = M_PAUSED;
                              else if (hit_end) m_state[i] = M_DONE;
                    M_PAUSED: if (se) m_state[i] = M_RUN;
                    default:  ;
                endcase
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s dut%0d min_tens", tag, i),  8'(mt[i]),  8'(m_secs[i] / 600));
            chk($sformatf("%s dut%0d min_units", tag, i), 8'(mu[i]),  8'((m_secs[i] / 60) % 10));
            chk($sformatf("%s dut%0d sec_tens", tag, i),  8'(st[i]),  8'((m_secs[i] % 60) / 10));
            chk($sformatf("%s dut%0d sec_units", tag, i), 8'(su[i]),  8'(m_secs[i] % 10));
            chk($sformatf("%s dut%0d state", tag, i),     8'(stt[i]), 8'(m_state[i]));
            chk($sformatf("%s dut%0d running", tag, i),   8'(run[i]), 8'(m_state[i] == M_RUN));
            chk($sformatf("%s dut%0d done", tag, i),      8'(dn[i]),  8'(m_state[i] == M_DONE));
            chk($sformatf("%s dut%0d ovf", tag, i),       8'(ov[i]),  8'(m_ovf[i]));
        end
    endtask

    // One clock edge; button events land on the edge their countdown reaches.
    task automatic step(input bit t);
        bit se, pe, ce;
        tick = t;
        se = (s_cd == 1); pe = (p_cd == 1); ce = (c_cd == 1);
        if (s_cd > 0) s_cd--;
        if (p_cd > 0) p_cd--;
        if (c_cd > 0) c_cd--;
        @(posedge clk);
        model_edge(se, pe, ce, t);
        #1;
        tick = 1'b0;
        if (!hold_start) start = 1'b0;
        pause = 1'b0;
        clr   = 1'b0;
        check_all("cycle");
    endtask

    task automatic press(input bit s, input bit p, input bit c);
        if (s) begin start = 1'b1; s_cd = 3; end
        if (p) begin pause = 1'b1; p_cd = 3; end
        if (c) begin clr   = 1'b1; c_cd = 3; end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic ticks(input int n, input int gap_max);
        for (int k = 0; k < n; k++) begin
            step(1'b1);
            if (gap_max > 0) idle(int'($urandom_range(gap_max, 0)));
        end
    endtask

    task automatic check_time(input string tag, input int a, input int b, input int c, input int d);
        chk({tag, " min_tens"},  8'(mt[0]), 8'(a));
        chk({tag, " min_units"}, 8'(mu[0]), 8'(b));
        chk({tag, " sec_tens"},  8'(st[0]), 8'(c));
        chk({tag, " sec_units"}, 8'(su[0]), 8'(d));
    endtask

    initial begin
        int r;
        // Reset with start already held.
        start = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        repeat (3) @(posedge clk);
        #1;
        check_all("reset held");
        rst = 1'b1;
        idle(4);
        chk("held start no event", 8'(stt[0]), 8'(M_IDLE));
        hold_start = 1'b0;
        idle(3);

        // Clean press acts on the third edge.
        press(1, 0, 0);
        step(1'b0);
        step(1'b0);
        chk("start edge2 still idle", 8'(stt[0]), 8'(M_IDLE));
        step(1'b0);
        chk("start edge3 run", 8'(stt[0]), 8'(M_RUN));

        // Run, pause, resume.
        ticks(75, 2);
        check_time("75 ticks", 0, 1, 1, 5);
        chk("75 ticks running", 8'(run[0]), 8'd1);
        press(0, 1, 0); idle(3);
        ticks(10, 1);
        check_time("paused ticks", 0, 1, 1, 5);
        chk("paused state", 8'(stt[0]), 8'(M_PAUSED));
        press(1, 0, 0); idle(3);
        ticks(5, 0);
        check_time("resumed", 0, 1, 2, 0);

        // Carry boundaries.
        press(0, 0, 1); idle(3);
        check_time("clr", 0, 0, 0, 0);
        press(1, 0, 0); idle(3);
        ticks(59, 0);
        check_time("00:59", 0, 0, 5, 9);
        ticks(1, 0);
        check_time("01:00", 0, 1, 0, 0);
        ticks(539, 0);
        check_time("09:59", 0, 9, 5, 9);
        ticks(1, 0);
        check_time("10:00", 1, 0, 0, 0);

        // End of range: stop versus wrap.
        ticks(2999, 0);
        check_time("59:59", 5, 9, 5, 9);
        step(1'b1);
        check_time("overflow hold", 5, 9, 5, 9);
        chk("overflow done", 8'(dn[0]), 8'd1);
        chk("wrap digits", 8'({mt[1], mu[1], st[1], su[1]}), 8'd0);
        chk("wrap ovf", 8'(ov[1]), 8'd1);
        chk("wrap state", 8'(stt[1]), 8'(M_RUN));
        step(1'b0);
        chk("wrap ovf one cycle", 8'(ov[1]), 8'd0);
        press(1, 0, 0); idle(3);
        press(0, 1, 0); idle(3);
        chk("done ignores buttons", 8'(stt[0]), 8'(M_DONE));
        press(0, 0, 1); idle(3);
        chk("done clr", 8'(stt[0]), 8'(M_IDLE));

        // Simultaneous events.
        press(1, 0, 0); idle(3);
        ticks(7, 0);
        press(0, 1, 0); step(1'b0); step(1'b0); step(1'b1);
        check_time("pause+tick", 0, 0, 0, 8);
        chk("pause+tick state", 8'(stt[0]), 8'(M_PAUSED));
        press(1, 0, 0); idle(3);
        ticks(3, 1);
        press(0, 0, 1); step(1'b0); step(1'b0); step(1'b1);
        check_time("clr+tick", 0, 0, 0, 0);
        chk("clr+tick state", 8'(stt[0]), 8'(M_IDLE));
        press(1, 0, 0); idle(3);
        press(0, 1, 0); idle(3);
        press(1, 1, 0); idle(3);
        chk("start+pause in paused", 8'(stt[0]), 8'(M_RUN));

        // Asynchronous reset mid-count.
        press(0, 0, 1); idle(3);
        press(1, 0, 0); idle(3);
        ticks(754, 0);
        check_time("12:34", 1, 2, 3, 4);
        rst = 1'b0;
        #2;
        model_reset();
        check_all("async reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        ticks(5, 0);
        check_time("no count after reset", 0, 0, 0, 0);
        press(1, 0, 0); idle(3);
        ticks(1, 0);
        check_time("count after start", 0, 0, 0, 1);

        // Random mix of buttons and ticks.
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(99, 0));
            if (r < 3 && c_cd == 0)       press(0, 0, 1);
            else if (r < 10 && s_cd == 0) press(1, 0, 0);
            else if (r < 16 && p_cd == 0) press(0, 1, 0);
            step($urandom_range(2, 0) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
